// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbiter for the shared seven-segment display value path.
// Latency: grant/owner/valid/pulse one edge after req; disp_data registered, tracks owner with one cycle delay.
// Backpressure: none; sources hold req high until granted and may release early via early_release[owner].
module seg_display_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DWELL  = 50_000_000,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(DWELL)
) (
  input  logic                      clk,
  input  logic                      rst_on,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  input  logic [N_REQ-1:0]          early_release,
  output logic [N_REQ-1:0]          grant,
  output logic [OW-1:0]             owner,
  output logic [DATA_W-1:0]         disp_data,
  output logic                      disp_valid,
  output logic                      switch_pulse
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_d;
  logic [OW-1:0]       last, last_d, owner_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [N_REQ-1:0]    grant_d;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d, pulse_d;

  logic [OW:0]               idle_pick, oth_pick, win_pick;
  logic [N_REQ-1:0]          own_mask, req_sh, rel_sh;
  logic [N_REQ*DATA_W-1:0]   own_sh, win_sh;
  logic [DATA_W-1:0]         own_data, win_data;
  logic                      own_req, own_rel, dwell_end, take;

  // Search base+1, base+2, ... (mod N_REQ); returns {found, index} of the first set mask bit.
  function automatic logic [OW:0] rr_pick(input logic [OW-1:0] base, input logic [N_REQ-1:0] mask);
    logic [OW:0]      r;
    logic [N_REQ-1:0] sh;
    int               idx;
    r = '0;
    // Walk from farthest to nearest so the nearest candidate overwrites the result.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(base) + k) % N_REQ;
      sh  = mask >> idx;
      if (sh[0]) r = {1'b1, OW'(idx)};
    end
    return r;
  endfunction

  // Candidate winners and owner-side views of the request, release and data inputs.
  always_comb begin
    own_mask  = N_REQ'(1) << owner;
    req_sh    = req >> owner;
    rel_sh    = early_release >> owner;
    own_req   = req_sh[0];
    own_rel   = rel_sh[0];
    dwell_end = (cnt == CW'(DWELL - 1));
    // In HOLD, last equals owner, so both searches start just after the owner.
    idle_pick = rr_pick(last, req);
    oth_pick  = rr_pick(owner, req & ~own_mask);
    win_pick  = (state == IDLE) ? idle_pick : oth_pick;
    own_sh    = data_in >> (int'(owner) * DATA_W);
    win_sh    = data_in >> (int'(win_pick[OW-1:0]) * DATA_W);
    own_data  = own_sh[DATA_W-1:0];
    win_data  = win_sh[DATA_W-1:0];
  end

  // Next-state and next-output decision: grant from IDLE, release/drop, dwell expiry.
  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    last_d  = last;
    cnt_d   = cnt;
    data_d  = disp_data;
    valid_d = disp_valid;
    pulse_d = 1'b0;
    take    = 1'b0;

    case (state)
      IDLE: begin
        if (idle_pick[OW]) take = 1'b1;
      end
      HOLD: begin
        if (!own_req || own_rel) begin
          // End of ownership wins over a coincident dwell expiry.
          if (oth_pick[OW]) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (dwell_end) begin
          if (oth_pick[OW]) begin
            take = 1'b1;
          end else begin
            // Nobody waiting: the owner keeps the display for another dwell period.
            cnt_d  = '0;
            data_d = own_data;
          end
        end else begin
          cnt_d  = cnt + CW'(1);
          data_d = own_data;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = HOLD;
      grant_d = N_REQ'(1) << win_pick[OW-1:0];
      owner_d = win_pick[OW-1:0];
      last_d  = win_pick[OW-1:0];
      cnt_d   = '0;
      data_d  = win_data;
      valid_d = 1'b1;
      pulse_d = 1'b1;
    end
  end

  // State, pointer, dwell counter and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_on) begin
    if (!rst_on) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      last         <= OW'(N_REQ - 1);
      cnt          <= '0;
      disp_data    <= '0;
      disp_valid   <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      owner        <= owner_d;
      last         <= last_d;
      cnt          <= cnt_d;
      disp_data    <= data_d;
      disp_valid   <= valid_d;
      switch_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed table-driven bench for seg_display_arbiter with N_REQ=4, DATA_W=8, DWELL=4.
// One vector per clock edge; outputs sampled 2 time units after the rising edge.
// Hand-written sequence covers asynchronous reset in the middle of an ownership.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_on;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  early_release;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        switch_pulse;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rel;
    logic [31:0] din;
    logic [3:0]  g;
    logic [1:0]  o;
    logic        v;
    logic        p;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] D_CNT = 32'h1312_1110;
  localparam logic [31:0] D_3C  = 32'h1312_113C;
  localparam logic [31:0] D_5A  = 32'h1312_115A;

  seg_display_arbiter #(.N_REQ(4), .DATA_W(8), .DWELL(4)) dut (
    .clk          (clk),
    .rst_on       (rst_on),
    .req          (req),
    .data_in      (data_in),
    .early_release(early_release),
    .grant        (grant),
    .owner        (owner),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] rl, input logic [31:0] dn,
                     input logic [3:0] g, input logic [1:0] o, input logic v,
                     input logic p, input logic [7:0] d);
    vec_t x;
    x.req = r; x.rel = rl; x.din = dn; x.g = g; x.o = o; x.v = v; x.p = p; x.d = d;
    tbl.push_back(x);
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] g, input logic [1:0] o,
                         input logic v, input logic p, input logic [7:0] d);
    chk({tag, "_grant"}, idx, 32'(grant), 32'(g));
    chk({tag, "_owner"}, idx, 32'(owner), 32'(o));
    chk({tag, "_valid"}, idx, 32'(disp_valid), 32'(v));
    chk({tag, "_pulse"}, idx, 32'(switch_pulse), 32'(p));
    chk({tag, "_data"}, idx, 32'(disp_data), 32'(d));
  endtask

  initial begin
    // Full contention from reset: owners 0,1,2,3,0 each for 4 cycles.
    for (int e = 0; e < 17; e++) begin
      int k;
      k = (e / 4) % 4;
      add(4'hF, 4'h0, D_CNT, 4'(1 << k), 2'(k), 1'b1, (e % 4) == 0, 8'(8'h10 + k));
    end
    // Early release: owner 0 at counter 1 releases, requester 1 waiting.
    add(4'b0011, 4'b0000, D_CNT, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h10);
    add(4'b0011, 4'b0001, D_CNT, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11);
    // Owner 1 with requester 3 waiting; release coincides with counter 3.
    add(4'b1010, 4'b0000, D_CNT, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h11);
    add(4'b1010, 4'b0000, D_CNT, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h11);
    add(4'b1010, 4'b0000, D_CNT, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h11);
    add(4'b1010, 4'b0010, D_CNT, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h13);
    // Non-owner release is ignored.
    add(4'b1000, 4'b0001, D_CNT, 4'b1000, 2'd3, 1'b1, 1'b0, 8'h13);
    add(4'b1000, 4'b0000, D_CNT, 4'b1000, 2'd3, 1'b1, 1'b0, 8'h13);
    // Owner drops with nobody waiting: idle, display value held.
    add(4'b0000, 4'b0000, D_CNT, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h13);
    // Single requester 0: one pulse, holds across dwell wraps, data tracks source.
    add(4'b0001, 4'b0000, D_3C, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h3C);
    add(4'b0001, 4'b0000, D_3C, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h3C);
    add(4'b0001, 4'b0000, D_3C, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h3C);
    for (int e = 0; e < 5; e++)
      add(4'b0001, 4'b0000, D_5A, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h5A);
    add(4'b0000, 4'b0000, D_5A, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h5A);
    add(4'b0000, 4'b0000, D_5A, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h5A);

    rst_on = 1'b0;
    req = '0;
    early_release = '0;
    data_in = D_CNT;
    #1;
    chk_all("reset", 0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_on = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      early_release = tbl[i].rel;
      data_in = tbl[i].din;
      @(posedge clk);
      #2;
      chk_all("vec", i, tbl[i].g, tbl[i].o, tbl[i].v, tbl[i].p, tbl[i].d);
    end

    // Grant owner 2, then assert reset between edges.
    req = 4'b0100;
    early_release = '0;
    data_in = D_CNT;
    @(posedge clk);
    #2;
    chk_all("own2", 0, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h12);
    #1 rst_on = 1'b0;
    #1;
    chk_all("async_rst", 0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    req = '0;
    @(posedge clk);
    #2 rst_on = 1'b1;
    req = 4'b1000;
    @(posedge clk);
    #2;
    chk_all("after_rst", 0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
